// File: rtl/mux_pkg.sv
//------------------------------------------------------------------------------
// Module      : mux_pkg
// Description : Shared widths and types for the mux result packing path.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

    localparam int DATA_W = 2;
    localparam int PACK   = 4;
    localparam int CNT_W  = $clog2(PACK) + 1;
    localparam int WORD_W = PACK * DATA_W;

    typedef logic [DATA_W-1:0]      beat_t;
    typedef logic [PACK*DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]       cnt_t;

endpackage

`default_nettype wire

// File: rtl/mux_result_hold.sv
//------------------------------------------------------------------------------
// Module      : mux_result_hold
// Description : One-entry valid/ready output register for a packed word and
//               its slot count. Produces the upstream ready.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_result_hold
    import mux_pkg::*;
#(
    parameter int WORD_W = $bits(word_t),
    parameter int CNT_W  = $bits(cnt_t)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_data_i,
    input  logic [CNT_W-1:0]  load_count_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [WORD_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  out_count_o,
    output logic              in_ready_o
);

    logic              r_valid_q, r_valid_d;
    logic [WORD_W-1:0] r_data_q,  r_data_d;
    logic [CNT_W-1:0]  r_count_q, r_count_d;

    // A slot opens when nothing is held or the held word leaves this cycle.
    assign in_ready_o = ~r_valid_q | out_ready_i;

    // Next state: a new word replaces the old one even on a transfer edge.
    always_comb begin
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_count_d = r_count_q;
        if (load_i) begin
            r_valid_d = 1'b1;
            r_data_d  = load_data_i;
            r_count_d = load_count_i;
        end else if (r_valid_q && out_ready_i) begin
            r_valid_d = 1'b0;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_count_q <= r_count_d;
        end
    end

    assign out_valid_o = r_valid_q;
    assign out_data_o  = r_data_q;
    assign out_count_o = r_count_q;

endmodule

`default_nettype wire

// File: rtl/mux_result_packer.sv
//------------------------------------------------------------------------------
// Module      : mux_result_packer
// Description : Packs successive mux results into a word, LSB slot first,
//               with early flush on in_last and a valid/ready word output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_result_packer #(
    parameter int DATA_W = mux_pkg::DATA_W,
    parameter int PACK   = mux_pkg::PACK,
    parameter int CNT_W  = $clog2(PACK) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PACK*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]       out_count
);

    localparam int PTR_W  = $clog2(PACK);
    localparam int WORD_W = PACK * DATA_W;

    logic [WORD_W-1:0] r_buf_q, r_buf_d;
    logic [PTR_W-1:0]  r_ptr_q, r_ptr_d;

    logic              w_accept;
    logic              w_close;
    logic [WORD_W-1:0] w_merged;
    logic [CNT_W-1:0]  w_count;

    assign w_accept = in_valid & in_ready;
    assign w_close  = (r_ptr_q == PTR_W'(PACK - 1)) | in_last;
    assign w_count  = CNT_W'(r_ptr_q) + CNT_W'(1);

    // Fill buffer with the incoming beat dropped into the current slot.
    always_comb begin
        w_merged = r_buf_q;
        for (int k = 0; k < PACK; k++) begin
            if (r_ptr_q == PTR_W'(k)) begin
                w_merged[k*DATA_W +: DATA_W] = in_data;
            end
        end
    end

    // Next fill state: advance on a normal beat, empty out on a closing beat.
    always_comb begin
        r_buf_d = r_buf_q;
        r_ptr_d = r_ptr_q;
        if (w_accept) begin
            if (w_close) begin
                r_buf_d = '0;
                r_ptr_d = '0;
            end else begin
                r_buf_d = w_merged;
                r_ptr_d = r_ptr_q + PTR_W'(1);
            end
        end
    end

    // Fill buffer and slot pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_q <= '0;
            r_ptr_q <= '0;
        end else begin
            r_buf_q <= r_buf_d;
            r_ptr_q <= r_ptr_d;
        end
    end

    mux_result_hold #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_hold (
        .clk          (clk),
        .rst          (rst),
        .load_i       (w_accept & w_close),
        .load_data_i  (w_merged),
        .load_count_i (w_count),
        .out_ready_i  (out_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_count_o  (out_count),
        .in_ready_o   (in_ready)
    );

endmodule

`default_nettype wire

// File: tb/tb_mux_result_packer.sv
`default_nettype none

module tb_mux_result_packer;

    localparam int PACK = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_count;

    int n_vec = 0;
    int n_err = 0;

    // reference model: beats collected so far plus the held word
    int   m_beats[$];
    logic m_valid;
    logic [7:0] m_data;
    logic [2:0] m_count;
    logic exp_rdy;
    logic act_rdy;

    mux_result_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    // one clock: drive inputs, capture ready before the edge, advance the model
    task automatic cycle(input logic r, input logic v, input logic [1:0] d,
                         input logic l, input logic ordy);
        int  word;
        logic acc;
        logic xfer;
        rst = r; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
        #2;
        exp_rdy = !m_valid || ordy;
        act_rdy = in_ready;
        @(posedge clk);
        acc  = v && exp_rdy;
        xfer = m_valid && ordy;
        if (r) begin
            m_beats.delete();
            m_valid = 1'b0; m_data = 8'h00; m_count = 3'd0;
        end else if (acc) begin
            m_beats.push_back(int'(d));
            if (l || m_beats.size() == PACK) begin
                word = 0;
                foreach (m_beats[k]) word += m_beats[k] * (4 ** k);
                m_valid = 1'b1;
                m_data  = word[7:0];
                m_count = 3'(m_beats.size());
                m_beats.delete();
            end else if (xfer) begin
                m_valid = 1'b0;
            end
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b1, 2'd3, 1'b1, 1'b1);
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_count !== 3'd0) begin
            n_err++;
            $display("FAIL reset: valid=%b data=%h count=%0d, want 0/00/0", out_valid, out_data, out_count);
        end
        rst = 1'b0; in_valid = 1'b0; #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_full_word;
        logic [1:0] b[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, b[i], 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h39 || out_count !== 3'd4) begin
            n_err++;
            $display("FAIL full_word: valid=%b data=%h count=%0d, want 1/39/4", out_valid, out_data, out_count);
        end
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_word_drop: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_partial;
        cycle(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h07 || out_count !== 3'd2) begin
            n_err++;
            $display("FAIL partial: valid=%b data=%h count=%0d, want 1/07/2", out_valid, out_data, out_count);
        end
        cycle(1'b0, 1'b1, 2'd2, 1'b1, 1'b1);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h02 || out_count !== 3'd1) begin
            n_err++;
            $display("FAIL partial_restart: valid=%b data=%h count=%0d, want 1/02/1", out_valid, out_data, out_count);
        end
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
            n_vec++;
            if (act_rdy !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hE4 || out_count !== 3'd4) begin
                n_err++;
                $display("FAIL stall[%0d]: rdy=%b valid=%b data=%h count=%0d, want 0/1/e4/4",
                         i, act_rdy, out_valid, out_data, out_count);
            end
        end
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        n_vec++;
        if (act_rdy !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL release: rdy=%b valid=%b, want 1/0", act_rdy, out_valid);
        end
        cycle(1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
        n_vec++;
        if (out_data !== 8'h05 || out_count !== 3'd2) begin
            n_err++;
            $display("FAIL after_stall: data=%h count=%0d, want 05/2", out_data, out_count);
        end
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [1:0] b[8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, b[i], 1'b0, 1'b1);
            n_vec++;
            if (act_rdy !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready[%0d]: rdy=%b want 1", i, act_rdy);
            end
            if (i == 3 || i == 7) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== (i == 3 ? 8'h39 : 8'hE4) || out_count !== 3'd4) begin
                    n_err++;
                    $display("FAIL b2b_word[%0d]: valid=%b data=%h count=%0d", i, out_valid, out_data, out_count);
                end
            end
        end
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic test_replace;
        cycle(1'b0, 1'b1, 2'd3, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 2'd2, 1'b1, 1'b1);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h02 || out_count !== 3'd1) begin
            n_err++;
            $display("FAIL replace: valid=%b data=%h count=%0d, want 1/02/1", out_valid, out_data, out_count);
        end
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        cycle(1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'hAA || out_count !== 3'd4) begin
            n_err++;
            $display("FAIL reset_mid: valid=%b data=%h count=%0d, want 1/aa/4", out_valid, out_data, out_count);
        end
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_held;
        cycle(1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0 || out_count !== 3'd0 || out_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_held: valid=%b data=%h count=%0d, want 0/00/0", out_valid, out_data, out_count);
        end
    endtask

    task automatic test_random;
        logic r, v, l, o;
        logic [1:0] d;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 4) == 0);
            o = ($urandom_range(0, 2) != 0);
            d = v ? 2'($urandom_range(0, 3)) : 2'bxx;
            cycle(r, v, d, l, o);
            n_vec++;
            if (act_rdy !== exp_rdy || out_valid !== m_valid ||
                (m_valid && (out_data !== m_data || out_count !== m_count))) begin
                n_err++;
                $display("FAIL random[%0d]: rdy=%b valid=%b data=%h count=%0d, want %b/%b/%h/%0d",
                         i, act_rdy, out_valid, out_data, out_count, exp_rdy, m_valid, m_data, m_count);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 2'd0; in_last = 1'b0; out_ready = 1'b0;
        m_valid = 1'b0; m_data = 8'h00; m_count = 3'd0;
        test_reset;
        test_full_word;
        test_partial;
        test_backpressure;
        test_back_to_back;
        test_replace;
        test_reset_mid;
        test_reset_held;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
